// File: rtl/spcore_lane.sv
// spcore_lane: one SIMT lane with a register file, ALU, predicate flag,
// writeback select, and a request/acknowledge memory port. Loads and stores
// park the lane in a wait state until mem_ack arrives.
module spcore_lane #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned N_REGS  = 16,
    parameter int unsigned CORE_ID = 0,
    parameter int unsigned N_CORES = 1,
    localparam int unsigned RAW    = $clog2(N_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic              en,
    input  logic [RAW-1:0]    x,
    input  logic [RAW-1:0]    y,
    input  logic [RAW-1:0]    z,
    input  logic [DATA_W-1:0] I,
    input  logic [3:0]        aluc,
    input  logic [1:0]        s2,
    input  logic              reg_we,
    input  logic              st,
    input  logic              pred_en,
    output logic              P,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam logic S_IDLE = 1'b0;
    localparam logic S_MEM  = 1'b1;

    logic              state;
    logic [DATA_W-1:0] regs [N_REGS];
    logic [DATA_W-1:0] a_val;
    logic [DATA_W-1:0] b_val;
    logic [DATA_W-1:0] c_val;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] wb_data;
    logic              p_next;
    logic              p_wr;
    logic              fire;
    logic              active;
    logic              is_store;
    logic              is_load;
    logic [RAW-1:0]    pend_x;
    logic              pend_we;

    assign issue_ready = (state == S_IDLE);

    // Operand fetch (R0 hard-wired to zero) and issue qualification
    always_comb begin
        a_val    = (x == '0) ? '0 : regs[x];
        b_val    = (y == '0) ? '0 : regs[y];
        c_val    = (z == '0) ? '0 : regs[z];
        fire     = issue_valid && issue_ready;
        active   = fire && en && !(pred_en && !P);
        is_store = active && st;
        is_load  = active && !st && (s2 == 2'd1);
        p_wr     = active && !st && (s2 == 2'd2) &&
                   ((aluc == 4'd12) || (aluc == 4'd13));
        wb_data  = (s2 == 2'd0) ? I : alu_res;
    end

    // ALU: results wrap to DATA_W bits; compare ops produce a predicate only
    always_comb begin
        alu_res = '0;
        p_next  = P;
        case (aluc)
            4'd0:  alu_res = a_val + b_val;
            4'd1:  alu_res = a_val - b_val;
            4'd2:  alu_res = a_val & b_val;
            4'd3:  alu_res = a_val | b_val;
            4'd4:  alu_res = a_val ^ b_val;
            4'd5:  alu_res = a_val << b_val[3:0];
            4'd6:  alu_res = a_val >> b_val[3:0];
            4'd7:  alu_res = a_val * b_val;
            4'd8:  alu_res = a_val * b_val + c_val;
            4'd9:  alu_res = a_val;
            4'd10: alu_res = DATA_W'(CORE_ID);
            4'd11: alu_res = DATA_W'(N_CORES);
            4'd12: p_next  = (a_val < b_val);
            4'd13: p_next  = (a_val == b_val);
            default: alu_res = '0;
        endcase
    end

    // Lane state: register writes, predicate, and memory handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_REGS; i++) regs[i] <= '0;
            P         <= 1'b0;
            state     <= S_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            pend_x    <= '0;
            pend_we   <= 1'b0;
        end else if (state == S_IDLE) begin
            if (is_store || is_load) begin
                state     <= S_MEM;
                mem_req   <= 1'b1;
                mem_we    <= is_store;
                mem_addr  <= b_val;
                mem_wdata <= is_store ? a_val : mem_wdata;
                pend_x    <= x;
                pend_we   <= is_load && reg_we;
            end else if (active) begin
                if (reg_we && (s2 != 2'd3) && (x != '0)) regs[x] <= wb_data;
                if (p_wr) P <= p_next;
            end
        end else if (mem_ack) begin
            if (pend_we && (pend_x != '0)) regs[pend_x] <= mem_rdata;
            mem_req <= 1'b0;
            state   <= S_IDLE;
        end
    end

endmodule
